arith_range_update: RTL

Range/low update and normalization stage of the AV1 arithmetic encoder. It sits directly downstream of the combinational `lut_v_module` (EC_MIN_PROB·(N−s) table). It drives that table's address, combines the returned offset with the CDF-scaled range products, and updates the encoder's `rng`/`low` state. It emits, per symbol, the pre-shift low, the shift count and the normalized range to the bitstream/carry stage.

---
 rtl/arith_range_update.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/arith_range_update.sv
// rtl/arith_range_update.sv - AV1 arithmetic encoder range/low update and normalization stage
module arith_range_update #(
  parameter int LOW_WIDTH      = 24,
  parameter int LUT_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_init,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_bool,
  input  logic                      i_bit,
  input  logic [15:0]               i_fl,
  input  logic [15:0]               i_fh,
  input  logic [3:0]                i_symbol,
  input  logic [4:0]                i_nsyms,
  output logic [7:0]                o_lut_addr,
  input  logic [LUT_DATA_WIDTH-1:0] i_lut_v,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [LOW_WIDTH:0]        o_low_pre,
  output logic [3:0]                o_shift,
  output logic [15:0]               o_range
);

  localparam int W = LOW_WIDTH + 1;

  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_bool_q, s1_bool_d;
  logic                      s1_bit_q, s1_bit_d;
  logic [15:0]               s1_fl_q, s1_fl_d;
  logic [9:0]                s1_fh_q, s1_fh_d;
  logic [LUT_DATA_WIDTH-1:0] s1_lut_q, s1_lut_d;
  logic [15:0]               rng_q, rng_d;
  logic [LOW_WIDTH-1:0]      low_q, low_d;
  logic                      o_valid_q, o_valid_d;
  logic [LOW_WIDTH:0]        o_low_pre_q, o_low_pre_d;
  logic [3:0]                o_shift_q, o_shift_d;
  logic [15:0]               o_range_q, o_range_d;

  logic                 advance, ready;
  logic [16:0]          q_fl, q_fh;
  logic [17:0]          u_m, v_m, v_b;
  logic [W-1:0]         low_pre;
  logic [15:0]          rng_new, range_norm;
  logic [3:0]           msb, shift;
  logic [LOW_WIDTH-1:0] low_norm;
  logic                 unused_in_bits;

  // N = nsyms-1 only needs its low nibble; nsyms=16 wraps 0-1 to 15.
  assign o_lut_addr     = {i_nsyms[3:0] - 4'd1, i_symbol};
  assign unused_in_bits = ^{i_nsyms[4], i_fh[5:0]};

  always_comb begin
    advance = !o_valid_q || i_ready;
    ready   = !i_init && (advance || !s1_valid_q);
  end

  assign o_ready = ready;

  // Range update: products use only rng[15:8] and the CDF's top 10 bits.
  always_comb begin
    q_fl = 17'((18'(rng_q[15:8]) * 18'(s1_fl_q[15:6])) >> 1);
    q_fh = 17'((18'(rng_q[15:8]) * 18'(s1_fh_q)) >> 1);
    u_m  = 18'(q_fl) + 18'(s1_lut_q) + 18'd4;
    v_m  = 18'(q_fh) + 18'(s1_lut_q);
    v_b  = 18'(q_fh) + 18'd4;

    low_pre = {1'b0, low_q};
    rng_new = rng_q;
    if (s1_bool_q) begin
      if (s1_bit_q) begin
        low_pre = {1'b0, low_q} + W'(rng_q) - W'(v_b);
        rng_new = 16'(v_b);
      end else begin
        rng_new = 16'(18'(rng_q) - v_b);
      end
    end else if (s1_fl_q == 16'h8000) begin
      rng_new = 16'(18'(rng_q) - v_m);
    end else begin
      low_pre = {1'b0, low_q} + W'(rng_q) - W'(u_m);
      rng_new = 16'(u_m - v_m);
    end

    msb = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (rng_new[i]) msb = 4'(i);
    end
    shift      = 4'd15 - msb;
    range_norm = rng_new << shift;
    low_norm   = LOW_WIDTH'(low_pre << shift);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_bool_d   = s1_bool_q;
    s1_bit_d    = s1_bit_q;
    s1_fl_d     = s1_fl_q;
    s1_fh_d     = s1_fh_q;
    s1_lut_d    = s1_lut_q;
    rng_d       = rng_q;
    low_d       = low_q;
    o_valid_d   = o_valid_q;
    o_low_pre_d = o_low_pre_q;
    o_shift_d   = o_shift_q;
    o_range_d   = o_range_q;
    if (i_init) begin
      s1_valid_d = 1'b0;
      o_valid_d  = 1'b0;
      rng_d      = 16'h8000;
      low_d      = '0;
    end else begin
      if (advance) begin
        o_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          o_low_pre_d = low_pre;
          o_shift_d   = shift;
          o_range_d   = range_norm;
          rng_d       = range_norm;
          low_d       = low_norm;
        end
      end
      if (ready) begin
        s1_valid_d = i_valid;
        if (i_valid) begin
          s1_bool_d = i_bool;
          s1_bit_d  = i_bit;
          s1_fl_d   = i_fl;
          s1_fh_d   = i_fh[15:6];
          s1_lut_d  = i_lut_v;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_bool_q   <= 1'b0;
      s1_bit_q    <= 1'b0;
      s1_fl_q     <= '0;
      s1_fh_q     <= '0;
      s1_lut_q    <= '0;
      rng_q       <= 16'h8000;
      low_q       <= '0;
      o_valid_q   <= 1'b0;
      o_low_pre_q <= '0;
      o_shift_q   <= '0;
      o_range_q   <= 16'h8000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_bool_q   <= s1_bool_d;
      s1_bit_q    <= s1_bit_d;
      s1_fl_q     <= s1_fl_d;
      s1_fh_q     <= s1_fh_d;
      s1_lut_q    <= s1_lut_d;
      rng_q       <= rng_d;
      low_q       <= low_d;
      o_valid_q   <= o_valid_d;
      o_low_pre_q <= o_low_pre_d;
      o_shift_q   <= o_shift_d;
      o_range_q   <= o_range_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_low_pre = o_low_pre_q;
  assign o_shift   = o_shift_q;
  assign o_range   = o_range_q;

endmodule
